// File: rtl/match_mon_pkg.sv
// Shared types and helpers for the match event monitor: FSM state encoding
// and a saturating adder used by the event counter and the running total.
package match_mon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // All-ones value of a field that is `width` bits wide (width <= 32).
  function automatic logic [31:0] all_ones(input int width);
    return (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
  endfunction

  // a + b clamped to max_val; the sum is formed one bit wider so it cannot wrap.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/match_win_timer.sv
// Window timer: counts WIN_LEN cycles once started, wraps at the end of each
// window and flags the last cycle with win_end. abort stops and zeroes it.
module match_win_timer #(
  parameter int WIN_LEN = 16
) (
  input  logic clk,
  input  logic rst_b,
  input  logic start,
  input  logic abort,
  output logic win_end
);

  localparam int CW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

  logic          active;
  logic [CW-1:0] win_cnt;

  assign win_end = active && (win_cnt == CW'(WIN_LEN - 1));

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values from before the edge regardless of order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      active  <= 1'b0;
      win_cnt <= '0;
    end else if (abort) begin
      active  <= 1'b0;
      win_cnt <= '0;
    end else if (start) begin
      active  <= 1'b1;
      win_cnt <= '0;
    end else if (active) begin
      win_cnt <= win_end ? '0 : win_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/match_event_monitor.sv
// Counts rising edges of the pattern detector output per WIN_LEN-cycle window
// and publishes each count on a valid/ready port with alarm and overrun flags.
// Define MATCH_MON_TOTAL_EN to add a saturating running total (total_count).
module match_event_monitor
  import match_mon_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 4
`ifdef MATCH_MON_TOTAL_EN
  , parameter int TOT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             en,
  input  logic             clr,
  input  logic             det_in,
  input  logic             cnt_ready,
  output logic [CNT_W-1:0] evt_count,
  output logic             cnt_valid,
  output logic             alarm,
  output logic             overrun,
  output logic             busy
`ifdef MATCH_MON_TOTAL_EN
  , output logic [TOT_W-1:0] total_count
`endif
);

  localparam logic [31:0] CNT_MAX = all_ones(CNT_W);

  state_t           state_q, state_d;
  logic             det_q;
  logic             event_hit;
  logic             win_end;
  logic             start;
  logic             abort;
  logic             publish;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pub_val;

  assign event_hit = det_in & ~det_q;
  // Count including an event on the current cycle; also the next counter value.
  assign pub_val   = sat_add(32'(cnt), 32'(event_hit), CNT_MAX);

  match_win_timer #(.WIN_LEN(WIN_LEN)) u_timer (
    .clk     (clk),
    .rst_b   (rst_b),
    .start   (start),
    .abort   (abort),
    .win_end (win_end)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    busy    = (state_q == RUN);
    start   = 1'b0;
    abort   = 1'b0;
    publish = 1'b0;
    if (clr) begin
      state_d = IDLE;
      abort   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_d = RUN;
            start   = 1'b1;
          end
        end
        RUN: begin
          publish = win_end;
          if (!en) begin
            state_d = IDLE;
            abort   = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The edge detector keeps tracking det_in even through clr and IDLE.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) det_q <= 1'b0;
    else        det_q <= det_in;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt       <= '0;
      evt_count <= '0;
      cnt_valid <= 1'b0;
      alarm     <= 1'b0;
      overrun   <= 1'b0;
    end else if (clr) begin
      cnt       <= '0;
      cnt_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (publish) begin
        evt_count <= CNT_W'(pub_val);
        alarm     <= (pub_val >= 32'(THRESH));
        cnt_valid <= 1'b1;
        if (cnt_valid && !cnt_ready) overrun <= 1'b1;
      end else if (cnt_valid && cnt_ready) begin
        cnt_valid <= 1'b0;
      end
      if (publish || state_q != RUN || !en) cnt <= '0;
      else                                  cnt <= CNT_W'(pub_val);
    end
  end

`ifdef MATCH_MON_TOTAL_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)       total_count <= '0;
    else if (clr)     total_count <= '0;
    else if (publish) total_count <= TOT_W'(sat_add(32'(total_count), pub_val, all_ones(TOT_W)));
  end
`endif

endmodule

// File: tb/tb_match_event_monitor.sv
// Randomized bench: a default instance and a CNT_W=2 instance share stimulus
// and are compared every cycle against a window-level reference model.
module tb_match_event_monitor;

  localparam int WIN = 16;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic det_in = 1'b0;
  logic cnt_ready = 1'b0;

  logic [7:0] evt_count;
  logic       cnt_valid, alarm, overrun, busy;
  logic [1:0] evt_count_s;
  logic       cnt_valid_s, alarm_s, overrun_s, busy_s;
`ifdef MATCH_MON_TOTAL_EN
  logic [15:0] total_count, total_count_s;
`endif

  always #5 clk = ~clk;

  match_event_monitor #(.CNT_W(8), .WIN_LEN(WIN), .THRESH(4)) dut (
    .clk(clk), .rst_b(rst_b), .en(en), .clr(clr), .det_in(det_in),
    .cnt_ready(cnt_ready), .evt_count(evt_count), .cnt_valid(cnt_valid),
    .alarm(alarm), .overrun(overrun), .busy(busy)
`ifdef MATCH_MON_TOTAL_EN
    , .total_count(total_count)
`endif
  );

  match_event_monitor #(.CNT_W(2), .WIN_LEN(WIN), .THRESH(3)) dut_small (
    .clk(clk), .rst_b(rst_b), .en(en), .clr(clr), .det_in(det_in),
    .cnt_ready(cnt_ready), .evt_count(evt_count_s), .cnt_valid(cnt_valid_s),
    .alarm(alarm_s), .overrun(overrun_s), .busy(busy_s)
`ifdef MATCH_MON_TOTAL_EN
    , .total_count(total_count_s)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: window position, raw event tally and the pending report.
  int m_prev, m_run, m_pos, m_events;
  int m_valid, m_over, m_count, m_count_s, m_alarm, m_alarm_s, m_total, m_total_s;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_run = 0; m_pos = 0; m_events = 0;
    m_valid = 0; m_over = 0; m_count = 0; m_count_s = 0;
    m_alarm = 0; m_alarm_s = 0; m_total = 0; m_total_s = 0;
  endtask

  task automatic model_step();
    int ev, old_valid, pub;
    ev = (det_in && !m_prev) ? 1 : 0;
    m_prev = int'(det_in);
    old_valid = m_valid;
    pub = 0;
    if (clr) begin
      m_run = 0; m_pos = 0; m_events = 0;
      m_valid = 0; m_over = 0; m_total = 0; m_total_s = 0;
    end else begin
      if (!m_run) begin
        if (en) begin
          m_run = 1; m_pos = 0; m_events = 0;
        end
      end else begin
        m_events += ev;
        if (m_pos == WIN - 1) begin
          pub = 1;
          if (old_valid && !cnt_ready) m_over = 1;
          m_count   = imin(m_events, 255);
          m_count_s = imin(m_events, 3);
          m_alarm   = (m_count >= 4) ? 1 : 0;
          m_alarm_s = (m_count_s >= 3) ? 1 : 0;
          m_total   = imin(m_total + m_count, 65535);
          m_total_s = imin(m_total_s + m_count_s, 65535);
          m_valid = 1; m_pos = 0; m_events = 0;
          m_run = en ? 1 : 0;
        end else if (!en) begin
          m_run = 0; m_pos = 0; m_events = 0;
        end else begin
          m_pos++;
        end
      end
      if (!pub && old_valid && cnt_ready) m_valid = 0;
    end
  endtask

  task automatic check_outputs();
    check("evt_count",   32'(evt_count),   32'(m_count));
    check("cnt_valid",   32'(cnt_valid),   32'(m_valid));
    check("alarm",       32'(alarm),       32'(m_alarm));
    check("overrun",     32'(overrun),     32'(m_over));
    check("busy",        32'(busy),        32'(m_run));
    check("evt_count_s", 32'(evt_count_s), 32'(m_count_s));
    check("alarm_s",     32'(alarm_s),     32'(m_alarm_s));
    check("overrun_s",   32'(overrun_s),   32'(m_over));
`ifdef MATCH_MON_TOTAL_EN
    check("total_count",   32'(total_count),   32'(m_total));
    check("total_count_s", 32'(total_count_s), 32'(m_total_s));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  // Asserts reset between edges; outputs must clear without waiting for clk.
  task automatic mid_cycle_reset();
    #2 rst_b = 1'b0;
    model_reset();
    #1 check_outputs();
    #1 rst_b = 1'b1;
  endtask

  initial begin
    int stall, dense;
    model_reset();
    #12 check_outputs();
    #10 rst_b = 1'b1;

    // Three single-cycle pulses in one window, consumer always ready.
    en = 1'b1;
    cnt_ready = 1'b1;
    for (int c = 0; c < 2 * WIN + 2; c++) begin
      det_in = (c == 2 || c == 5 || c == 9);
      tick();
    end

    // Long high level plus separate pulses.
    for (int c = 0; c < 2 * WIN; c++) begin
      det_in = (c < 10) || (c == 11) || (c == 13) || (c == 15) || (c == 17) || (c == 19);
      tick();
    end

    // Drop en mid-window, then a reset in the middle of a running window.
    for (int c = 0; c < 12; c++) begin
      en = (c != 8);
      det_in = c[0];
      tick();
    end
    mid_cycle_reset();

    stall = 0;
    dense = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        stall = ($urandom_range(0, 2) == 0) ? 1 : 0;
        dense = ($urandom_range(0, 2) == 0) ? 1 : 0;
      end
      clr = ($urandom_range(0, 199) == 0);
      if (en) en = ($urandom_range(0, 59) != 0);
      else    en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, dense ? 1 : 3) == 0) det_in = ~det_in;
      cnt_ready = stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      tick();
      if ($urandom_range(0, 499) == 0) mid_cycle_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
